// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: captures a WIDTH-bit word on a ready/load handshake and shifts it
// out LSB-first with first/last/done frame markers for a downstream serial stage.
module serial_word_feeder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             x_out,
  output logic             bit_valid,
  output logic             first_bit,
  output logic             last_bit,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // load is only looked at in StIdle, so an X on it while busy cannot disturb state.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          shreg_d = data_in;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode purely from registered state.
  always_comb begin
    ready     = 1'b0;
    bit_valid = 1'b0;
    x_out     = 1'b0;
    first_bit = 1'b0;
    last_bit  = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
      end
      StShift: begin
        bit_valid = 1'b1;
        x_out     = shreg_q[0];
        first_bit = (cnt_q == '0);
        last_bit  = (cnt_q == CntLast);
      end
      StDone: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/serial_word_feeder.md
Name: serial_word_feeder

Overview:
- Upstream stage for the serial two's-complementer FSM.
- Accepts a parallel WIDTH-bit word through a ready/load handshake and shifts it out LSB-first, one bit per clock, on x_out.
- Frame markers (first_bit, last_bit, done) let the downstream stage clear its state between words and let a collector reassemble the result.

Parameters:
- WIDTH, 8, word length in bits; legal range is WIDTH >= 2.
- CW, $clog2(WIDTH), bit-counter width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- load  input  1  request to capture data_in; honoured only when ready=1.
- data_in  input  WIDTH  parallel word to serialise.
- ready  output  1  feeder is idle and will accept load this cycle.
- x_out  output  1  current serial bit; LSB first.
- bit_valid  output  1  x_out carries a valid word bit this cycle.
- first_bit  output  1  high on the bit-0 cycle only.
- last_bit  output  1  high on the bit-(WIDTH-1) cycle only.
- done  output  1  one-cycle pulse, the cycle after last_bit.

Behaviour:
- Reset (rstn=0, async):
  - state=IDLE, shift register=0, counter=0.
  - ready=1; x_out, bit_valid, first_bit, last_bit and done all 0.
  - Takes effect immediately, including mid-word. The partial word is discarded and nothing resumes after release.
- States: IDLE, SHIFT, DONE. All outputs decode from registered state, counter and shift-register LSB; there is no combinational path from load or data_in to any output.
- IDLE:
  - ready=1, bit_valid=0, x_out=0.
  - On a posedge with load=1: shreg<=data_in, cnt<=0, go to SHIFT.
  - load=0 stays in IDLE.
- SHIFT:
  - ready=0, bit_valid=1, x_out=shreg[0].
  - first_bit=(cnt==0); last_bit=(cnt==WIDTH-1).
  - Each posedge: shreg<=shreg>>1 with zero fill, cnt<=cnt+1.
  - When cnt==WIDTH-1: go to DONE and cnt<=0; the counter never wraps past WIDTH-1.
- DONE:
  - done=1, ready=0, bit_valid=0, x_out=0.
  - Unconditionally go to IDLE next posedge.
  - This gap cycle is the downstream clear slot.
- Latency and throughput:
  - Load accepted at edge N: bit 0 is on x_out during cycle N+1 and bit WIDTH-1 during cycle N+WIDTH.
  - done is high during cycle N+WIDTH+1; ready returns during cycle N+WIDTH+2.
  - Maximum throughput is one word per WIDTH+2 cycles.
- Boundary conditions:
  - load while ready=0 (SHIFT or DONE) is ignored and not queued.
  - Changes to data_in after capture have no effect on the word in flight.
  - load held continuously high: a new word is captured at every edge where state=IDLE.
  - X on load while in SHIFT or DONE must not disturb state.
  - first_bit and last_bit are never high in the same cycle (guaranteed by WIDTH >= 2).

Test Plan:
- Reset: rstn=0 at t=0, released at t=10 -> ready=1; x_out, bit_valid, first_bit, last_bit, done all 0.
- Single word: WIDTH=8, data_in=8'h2C, load pulse accepted at edge N:
  - x_out over cycles N+1..N+8 = 0,0,1,1,0,1,0,0.
  - first_bit only at N+1, last_bit only at N+8, done only at N+9, ready=1 at N+10.
  - Through the complementer the serial result is 8'hD4.
- Ignored load: load=1 with data_in=8'hFF during the 3rd SHIFT cycle of word 8'h2C -> bit sequence unchanged, no extra word emitted.
- Reset mid-word: rstn=0 during bit 3 of 8'hA5 -> same cycle, bit_valid=0, x_out=0, ready=1. After release, a new load of 8'h01 emits 1,0,0,0,0,0,0,0.
- Back-to-back: load held high, data_in=8'h80 then 8'h00 -> words start 10 cycles apart.
  - 8'h80 yields a single 1 on bit 7 with last_bit; 8'h00 yields all zeros.
  - done pulses exactly twice.
- WIDTH=2 build: data_in=2'b10 -> x_out 0 then 1, with first_bit then last_bit; done on the 3rd cycle.
